// File: rtl/dna_pkg.sv
// Shared types and helpers for the base-4 (DNA) differential word coder pair.
package dna_pkg;

  typedef logic [1:0] dna_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_HOLD   = 2'd2
  } dec_state_t;

  // 2-bit add wraps naturally, giving the mod-4 sum.
  function automatic dna_digit_t mod4_add(input dna_digit_t a, input dna_digit_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/diff_word_decoder.sv
// Differential word decoder: rebuilds base-4 digits MSD-first by running mod-4
// accumulation, one digit per clock, with optional chaining across words.
module diff_word_decoder
  import dna_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_word,
  input  logic           in_sof,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_word,
  output logic           out_sof
);

  localparam int CNT_W = $clog2(N);

  dec_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  dna_digit_t       r_enc [N];
  dna_digit_t       r_dec [N];
  dna_digit_t       r_prev;
  dna_digit_t       r_last;
  logic             r_sof;
  logic             r_out_valid;
  logic             r_out_sof;

  logic       w_accept;
  dna_digit_t w_last_src;
  dna_digit_t w_digit;

  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready);
  assign w_accept = in_valid & in_ready;

  // A word accepted in the HOLD handshake chains onto the word being released.
  assign w_last_src = (r_state == ST_HOLD) ? r_dec[0] : r_last;
  assign w_digit    = mod4_add(r_enc[r_cnt], r_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_last      <= '0;
      r_sof       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_enc[i] <= '0;
        r_dec[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_DECODE: begin
          r_dec[r_cnt] <= w_digit;
          r_prev       <= w_digit;
          if (r_cnt == '0) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_sof   <= r_sof;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_last      <= r_dec[0];
            r_state     <= ST_IDLE;
          end
        end
        default: ;
      endcase

      if (w_accept) begin
        for (int i = 0; i < N; i++) begin
          r_enc[i] <= in_word[2*i +: 2];
        end
        r_sof   <= in_sof;
        r_prev  <= in_sof ? 2'd0 : w_last_src;
        r_cnt   <= CNT_W'(N - 1);
        r_state <= ST_DECODE;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign out_word[2*gi +: 2] = r_dec[gi];
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;

endmodule

// File: tb/tb_diff_word_decoder.sv
// Self-checking bench for diff_word_decoder (N=4): directed scenarios plus a
// randomized encode/decode round trip with valid/ready stalls.
module tb_diff_word_decoder;

  localparam int N = 4;
  localparam int W = 2 * N;
  localparam int M = 60;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_word;
  logic         in_sof;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         out_sof;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  diff_word_decoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_sof   (out_sof)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: enc[i] = d[i] - prev (mod 4), prev starts at 0 or the
  // last digit of the previous original word.
  function automatic logic [W-1:0] enc_model(input logic [W-1:0] d, input logic sof,
                                             input logic [1:0] last);
    logic [W-1:0] e;
    int prev;
    int dig;
    e = '0;
    prev = sof ? 0 : int'(last);
    for (int i = N - 1; i >= 0; i--) begin
      dig = int'(d[2*i +: 2]);
      e[2*i +: 2] = 2'((dig - prev + 4) % 4);
      prev = dig;
    end
    return e;
  endfunction

  // Present a word in IDLE and let it be accepted on the next edge.
  task automatic accept_word(input logic [W-1:0] w, input logic sof);
    in_word  = w;
    in_sof   = sof;
    in_valid = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
      n_fail++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // After an accept edge, check out_valid rises exactly N edges later.
  task automatic wait_latency(input string name);
    for (int c = 1; c < N; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        $display("FAIL %s_early: out_valid=%b at cycle %0d required 0", name, out_valid, c);
        n_fail++;
      end
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s_latency: out_valid=%b at cycle %0d required 1", name, out_valid, N);
      n_fail++;
    end
  endtask

  task automatic check_out(input string name, input logic [W-1:0] w, input logic sof);
    n_tests++;
    if (out_word !== w || out_sof !== sof) begin
      $display("FAIL %s: out_word=%h out_sof=%b required %h %b", name, out_word, out_sof, w, sof);
      n_fail++;
    end else begin
      $display("[TB] %s: out_word=%h out_sof=%b ok", name, out_word, out_sof);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drain: out_valid=%b required 0", out_valid);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_word = '0; in_sof = 1'b0;
    tick(); tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_word !== '0 || out_sof !== 1'b0) begin
      $display("FAIL reset_outputs: valid=%b word=%h sof=%b required 0 00 0", out_valid, out_word, out_sof);
      n_fail++;
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
      n_fail++;
    end
    $display("[TB] reset done");
  endtask

  task automatic test_standalone();
    accept_word(8'h15, 1'b1);
    wait_latency("standalone");
    check_out("standalone", 8'h1B, 1'b1);
    drain();
  endtask

  task automatic test_wrap();
    accept_word(8'hFF, 1'b1);
    wait_latency("wrap");
    check_out("wrap", 8'hE4, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    accept_word(8'h15, 1'b1);
    in_valid = 1'b1; in_word = 8'h40; in_sof = 1'b0;
    wait_latency("chain_first");
    check_out("chain_first", 8'h1B, 1'b1);
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL chain_hold_ready: in_ready=%b required 1", in_ready);
      n_fail++;
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL chain_no_bubble: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
      n_fail++;
    end
    wait_latency("chain_second");
    check_out("chain_second", 8'h00, 1'b0);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    accept_word(8'h15, 1'b1);
    wait_latency("bp");
    in_valid = 1'b1; in_word = 8'hFF; in_sof = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_word !== 8'h1B || in_ready !== 1'b0) begin
        $display("FAIL bp_hold: cycle %0d valid=%b word=%h in_ready=%b required 1 1b 0",
                 c, out_valid, out_word, in_ready);
        n_fail++;
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready);
      n_fail++;
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL bp_accepted: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
      n_fail++;
    end
    wait_latency("bp_second");
    check_out("bp_second", 8'hE4, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    // Leave last = 3 so a failure to clear it would be visible.
    accept_word(8'h15, 1'b1);
    wait_latency("rm_prep");
    drain();
    accept_word(8'hFF, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_decode: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      n_fail++;
    end
    tick();
    rst = 1'b0;
    tick();
    accept_word(8'h15, 1'b0);
    wait_latency("rm_after");
    check_out("reset_mid_last_cleared", 8'h1B, 1'b0);
    // Reset while holding a finished word.
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_word !== '0) begin
      $display("FAIL reset_hold: out_valid=%b out_word=%h required 0 00", out_valid, out_word);
      n_fail++;
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic         exp_sof_q[$];
    logic [W-1:0] d;
    logic [W-1:0] ew;
    logic [W-1:0] ow;
    logic         es;
    logic         os;
    logic         sof;
    logic         acc;
    logic         emit;
    logic [1:0]   last_orig;
    int           produced;
    int           received;
    int           cyc;
    produced = 0; received = 0; cyc = 0; last_orig = 2'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (received < M && cyc < 20000) begin
      if (!in_valid) begin
        in_word = W'($urandom);
        in_sof  = 1'($urandom);
        if (produced < M && $urandom_range(0, 3) != 0) begin
          d   = W'($urandom);
          sof = (produced == 0) || ($urandom_range(0, 3) == 0);
          in_word   = enc_model(d, sof, last_orig);
          in_sof    = sof;
          last_orig = d[1:0];
          exp_q.push_back(d);
          exp_sof_q.push_back(sof);
          produced++;
          in_valid = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      ow   = out_word;
      os   = out_sof;
      tick();
      cyc++;
      if (acc) in_valid = 1'b0;
      if (emit) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra: unexpected word %h", ow);
          n_fail++;
        end else begin
          ew = exp_q.pop_front();
          es = exp_sof_q.pop_front();
          if (ow !== ew || os !== es) begin
            $display("FAIL rand_word %0d: out_word=%h out_sof=%b required %h %b", received, ow, os, ew, es);
            n_fail++;
          end else begin
            $display("[TB] rand word %0d: %h sof=%b ok", received, ow, os);
          end
        end
        received++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (received != M || exp_q.size() != 0) begin
      $display("FAIL rand_count: received=%0d pending=%0d required %0d 0", received, exp_q.size(), M);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_standalone();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_word_decoder.md
Name: diff_word_decoder

Overview:
- Inverse of the differential word encoder.
- Accepts differentially encoded words of N base-4 (DNA) digits over a valid/ready handshake and reconstructs the original digits by running mod-4 accumulation.
- Decodes one digit per clock, most-significant digit first; an FSM sequences the work.
- Sits on the receive/read-back path after the channel. Words can be decoded standalone, or chained so a sequence spans several words.

Parameters:
- N, 8, number of 2-bit digits per word (N >= 2).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  encoded word available.
- in_ready  output  1  decoder can accept a word this cycle.
- in_word  input  2N  encoded word; digit i = bits [2i+1:2i], digit N-1 leftmost.
- in_sof  input  1  start of sequence; sampled with in_word.
- out_valid  output  1  decoded word available.
- out_ready  input  1  downstream accepts the decoded word.
- out_word  output  2N  decoded word, same digit ordering as in_word.
- out_sof  output  1  in_sof of the word now on out_word.

Behaviour:
- Encoding being inverted:
  - enc[N-1] = d[N-1].
  - enc[i] = (d[i] - d[i+1]) mod 4.
- Decode rule: dec[i] = (enc[i] + dec[i+1]) mod 4, for i = N-2 down to 0.
- Leftmost digit:
  - dec[N-1] = enc[N-1] when in_sof = 1.
  - dec[N-1] = (enc[N-1] + last) mod 4 when in_sof = 0.
  - last is dec[0] of the previous decoded word.
- Arithmetic is 2-bit, wrapping mod 4; there is no overflow flag.
- FSM states are IDLE, DECODE and HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_word and in_sof, set the digit counter to N-1, go to DECODE.
- DECODE:
  - Each cycle, compute the digit at the counter position, write it into the output register, and update the running-previous digit.
  - Decrement the counter.
  - After digit 0 is written, go to HOLD.
  - Exactly N cycles are spent in DECODE.
- HOLD:
  - out_valid = 1.
  - out_word and out_sof are stable until out_valid & out_ready.
  - On that handshake, `last` takes dec[0].
  - If in_valid is also high in the same cycle, the new word is captured and the FSM goes directly to DECODE. `last` used by that new word is the word just completed.
  - Otherwise the FSM goes to IDLE.
- in_ready = (state == IDLE) or (state == HOLD and out_ready).
  - in_ready is combinational from out_ready.
  - There is no combinational path from in_valid to any output.
- Latency: word accepted at edge k; out_valid asserts after edge k+N. Throughput is one word per N+1 cycles at full rate.
- out_valid is low in IDLE and DECODE. Partial results are never visible as valid.
- Reset values: state = IDLE, out_valid = 0, out_word = 0, out_sof = 0, last = 0, counter = 0; in_ready = 1 one cycle after reset deasserts.
- Reset mid-DECODE or mid-HOLD: the word is discarded, nothing is emitted, and `last` is cleared to 0. A subsequent in_sof = 0 word therefore decodes as if last = 0.
- in_word and in_sof are ignored when not handshaking.
- The captured word is unaffected by input changes during DECODE.

Decomposition:
- Shared package dna_pkg:
  - typedef dna_digit_t (2-bit).
  - enum for the FSM states.
  - function mod4_add.
- The encoder may be refactored to use the same package.
- No sub-module is needed: the datapath is one mod-4 adder, a digit mux on the counter, and a shift/indexed write into the output register.
- The FSM and datapath live in the single module.

Test Plan (N=4):
- Standalone decode: after reset, in_sof=1, in_word=0x15 -> out_word=0x1B, out_sof=1. out_valid rises exactly 4 cycles after the accept edge.
- Wrap-around: in_sof=1, in_word=0xFF -> out_word=0xE4 (digits 3,2,1,0).
- Chaining: 0x15 with sof=1, then 0x40 with sof=0 -> second out_word=0x00, because last=3 and 3+1 wraps to 0. Both words are sent back-to-back with out_ready held high; the second is accepted in the HOLD handshake cycle with no IDLE bubble.
- Backpressure: out_ready low for 5 cycles in HOLD -> out_valid stays 1, out_word is constant, and in_ready=0 with in_valid high. When out_ready rises, the pending input is accepted in the same cycle.
- Reset mid-operation: assert rst 2 cycles into DECODE -> out_valid=0 immediately, state=IDLE. Then in_sof=0, in_word=0x15 -> out_word=0x1B, since last was cleared to 0.
- Randomised round-trip: random N=4 words through the encoder model, then the decoder, with random valid/ready stalls -> decoded stream equals the original, in order and with no drops or duplicates.
